// File: rtl/io_bus_decoder_pkg.sv
// Shared constants and types for the I/O bus decoder.
// State encodings, slave count, float value, lane-fill helper.
package io_bus_decoder_pkg;

   localparam int SLV_COUNT = 4;

   localparam logic [31:0] IO_FLOAT = 32'hFFFF_FFFF;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_READ_WAIT = 2'd1;
   localparam logic [1:0] ST_READ_FILL = 2'd2;

   typedef struct packed {
      logic [SLV_COUNT-1:0] sel;
      logic [3:0]           be;
      logic [15:0]          addr;
   } rd_ctx_t;

   // Disabled byte lanes read back as floating bus (all ones).
   function automatic logic [31:0] lane_fill(
      input logic [31:0] data,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = data;
      for (int i = 0; i < 4; i++) begin
         if (!be[i]) r[8*i +: 8] = 8'hFF;
      end
      return r;
   endfunction

endpackage

// File: rtl/io_bus_decoder_window_match.sv
// Address window matcher for the I/O bus decoder.
// Lowest-index window wins when windows overlap.
module io_window_match
   import io_bus_decoder_pkg::*;
(
   input  logic [15:0]             address,
   input  logic [SLV_COUNT*16-1:0] bases,
   input  logic [SLV_COUNT*16-1:0] masks,
   output logic [SLV_COUNT-1:0]    hit_onehot,
   output logic                    hit
);

   localparam logic [SLV_COUNT-1:0] ONE = 1;

   logic [SLV_COUNT-1:0] raw;

   // Raw per-window compare of masked address against base.
   always_comb begin
      raw = '0;
      for (int i = 0; i < SLV_COUNT; i++) begin
         raw[i] = (address & masks[16*i +: 16])
                  == bases[16*i +: 16];
      end
   end

   // Isolate the lowest set bit to resolve overlaps.
   assign hit_onehot = raw & (~raw + ONE);
   assign hit        = |raw;

endmodule

// File: rtl/io_bus_decoder.sv
// I/O-space Avalon decoder to four peripheral slaves.
// Synthetic responses for unmapped ports and hung slaves.
module io_bus_decoder
   import io_bus_decoder_pkg::*;
#(
   parameter logic [15:0] SLV0_BASE = 16'h0000,
   parameter logic [15:0] SLV0_MASK = 16'hFFE0,
   parameter logic [15:0] SLV1_BASE = 16'h0020,
   parameter logic [15:0] SLV1_MASK = 16'hFFE0,
   parameter logic [15:0] SLV2_BASE = 16'h0040,
   parameter logic [15:0] SLV2_MASK = 16'hFFE0,
   parameter logic [15:0] SLV3_BASE = 16'h0060,
   parameter logic [15:0] SLV3_MASK = 16'hFFE0,
   parameter logic [15:0] TIMEOUT   = 16'd255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [15:0]  avalon_io_address,
   input  logic [3:0]   avalon_io_byteenable,
   input  logic         avalon_io_read,
   input  logic         avalon_io_write,
   input  logic [31:0]  avalon_io_writedata,
   output logic         avalon_io_waitrequest,
   output logic         avalon_io_readdatavalid,
   output logic [31:0]  avalon_io_readdata,
   output logic [15:0]  slv_address,
   output logic [3:0]   slv_byteenable,
   output logic [31:0]  slv_writedata,
   output logic [3:0]   slv_read,
   output logic [3:0]   slv_write,
   input  logic [127:0] slv_readdata,
   input  logic [3:0]   slv_readdatavalid,
   input  logic [3:0]   slv_waitrequest,
   output logic         io_timeout,
   output logic [15:0]  io_timeout_address
);

   logic [1:0]  state;
   logic [1:0]  state_nx;
   logic [15:0] cnt;
   logic [15:0] cnt_nx;
   rd_ctx_t     ctx;
   logic        ctx_load;

   logic [SLV_COUNT-1:0] hit_onehot;
   logic                 hit;
   logic [SLV_COUNT-1:0] strobe;

   logic        req;
   logic        stall;
   logic        rsp_hit;
   logic [31:0] rsp_data;
   logic        waitreq;
   logic        fire;
   logic [15:0] fire_addr;
   logic        rdv_set;
   logic [31:0] rd_nx;
   logic [15:0] to_addr_q;

   io_window_match u_match (
      .address    (avalon_io_address),
      .bases      ({SLV3_BASE, SLV2_BASE,
                    SLV1_BASE, SLV0_BASE}),
      .masks      ({SLV3_MASK, SLV2_MASK,
                    SLV1_MASK, SLV0_MASK}),
      .hit_onehot (hit_onehot),
      .hit        (hit)
   );

   assign req     = avalon_io_read | avalon_io_write;
   assign stall   = |(hit_onehot & slv_waitrequest);
   assign rsp_hit = |(slv_readdatavalid & ctx.sel);

   // Pick the pending slave's data lane.
   always_comb begin
      rsp_data = '0;
      for (int i = 0; i < SLV_COUNT; i++) begin
         rsp_data = rsp_data
                  | (slv_readdata[32*i +: 32]
                     & {32{ctx.sel[i]}});
      end
   end

   // Next-state, handshake and completion decisions.
   always_comb begin
      state_nx  = state;
      cnt_nx    = '0;
      ctx_load  = 1'b0;
      strobe    = '0;
      waitreq   = 1'b0;
      fire      = 1'b0;
      fire_addr = ctx.addr;
      rdv_set   = 1'b0;
      rd_nx     = IO_FLOAT;
      unique case (state)
         ST_IDLE: begin
            if (req && hit) begin
               if (stall && cnt == TIMEOUT) begin
                  fire      = 1'b1;
                  fire_addr = avalon_io_address;
                  if (avalon_io_read) begin
                     state_nx = ST_READ_FILL;
                     rdv_set  = 1'b1;
                  end
               end else begin
                  strobe  = hit_onehot;
                  waitreq = stall;
                  if (stall) begin
                     cnt_nx = cnt + 16'd1;
                  end else if (avalon_io_read) begin
                     state_nx = ST_READ_WAIT;
                     ctx_load = 1'b1;
                  end
               end
            end else if (avalon_io_read) begin
               state_nx = ST_READ_FILL;
               rdv_set  = 1'b1;
            end
         end
         ST_READ_WAIT: begin
            waitreq = 1'b1;
            if (rsp_hit) begin
               rdv_set  = 1'b1;
               rd_nx    = lane_fill(rsp_data, ctx.be);
               state_nx = ST_IDLE;
            end else if (cnt == TIMEOUT) begin
               fire     = 1'b1;
               rdv_set  = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         ST_READ_FILL: begin
            waitreq  = 1'b1;
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State, stall counter and pending read context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ctx   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (ctx_load) begin
            ctx.sel  <= hit_onehot;
            ctx.be   <= avalon_io_byteenable;
            ctx.addr <= avalon_io_address;
         end
      end
   end

   // Registered read completion toward the master.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avalon_io_readdatavalid <= 1'b0;
         avalon_io_readdata      <= '0;
      end else begin
         avalon_io_readdatavalid <= rdv_set;
         if (rdv_set) avalon_io_readdata <= rd_nx;
      end
   end

   // Hold the address of the most recent timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_addr_q <= '0;
      end else if (fire) begin
         to_addr_q <= fire_addr;
      end
   end

   assign io_timeout         = fire;
   assign io_timeout_address = fire ? fire_addr : to_addr_q;

   assign avalon_io_waitrequest = waitreq;

   assign slv_address    = avalon_io_address;
   assign slv_byteenable = avalon_io_byteenable;
   assign slv_writedata  = avalon_io_writedata;
   assign slv_read  = avalon_io_read  ? strobe : 4'b0000;
   assign slv_write = avalon_io_write ? strobe : 4'b0000;

endmodule

// File: tb/tb_io_bus_decoder.sv
// Self-checking bench for io_bus_decoder.
// Decode table, directed corner cases, random transactions.
module tb_io_bus_decoder;

   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [15:0]  avalon_io_address = '0;
   logic [3:0]   avalon_io_byteenable = '0;
   logic         avalon_io_read = 1'b0;
   logic         avalon_io_write = 1'b0;
   logic [31:0]  avalon_io_writedata = '0;
   logic         avalon_io_waitrequest;
   logic         avalon_io_readdatavalid;
   logic [31:0]  avalon_io_readdata;
   logic [15:0]  slv_address;
   logic [3:0]   slv_byteenable;
   logic [31:0]  slv_writedata;
   logic [3:0]   slv_read;
   logic [3:0]   slv_write;
   logic [127:0] slv_readdata = '0;
   logic [3:0]   slv_readdatavalid = '0;
   logic [3:0]   slv_waitrequest = '0;
   logic         io_timeout;
   logic [15:0]  io_timeout_address;

   int errors = 0;
   int checks = 0;

   io_bus_decoder #(.TIMEOUT(16'd4)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .avalon_io_address       (avalon_io_address),
      .avalon_io_byteenable    (avalon_io_byteenable),
      .avalon_io_read          (avalon_io_read),
      .avalon_io_write         (avalon_io_write),
      .avalon_io_writedata     (avalon_io_writedata),
      .avalon_io_waitrequest   (avalon_io_waitrequest),
      .avalon_io_readdatavalid (avalon_io_readdatavalid),
      .avalon_io_readdata      (avalon_io_readdata),
      .slv_address             (slv_address),
      .slv_byteenable          (slv_byteenable),
      .slv_writedata           (slv_writedata),
      .slv_read                (slv_read),
      .slv_write               (slv_write),
      .slv_readdata            (slv_readdata),
      .slv_readdatavalid       (slv_readdatavalid),
      .slv_waitrequest         (slv_waitrequest),
      .io_timeout              (io_timeout),
      .io_timeout_address      (io_timeout_address)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h",
                  name, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_fill(
      input logic [31:0] d, input logic [3:0] be);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic idle_inputs();
      avalon_io_read    = 1'b0;
      avalon_io_write   = 1'b0;
      slv_waitrequest   = '0;
      slv_readdatavalid = '0;
      slv_readdata      = '0;
   endtask

   // One master transaction; slave stalls s cycles,
   // a read answer comes d cycles after acceptance.
   task automatic run_txn(input string tag,
                          input logic [15:0] a,
                          input logic [3:0] be,
                          input bit rd,
                          input logic [31:0] wd,
                          input logic [31:0] sd,
                          input int s,
                          input int d);
      bit mapped;
      int tgt;
      int exp_wait;
      bit exp_to;
      logic [31:0] exp_data;
      int waits, valids, pulses, serr, since, stall_left;
      bit active, exp_w;
      logic [31:0] got;
      logic [15:0] to_a;
      logic [3:0] exp_st;
      mapped   = (a < 16'h0080);
      tgt      = int'(a[6:5]);
      exp_data = 32'hFFFF_FFFF;
      exp_to   = 1'b0;
      exp_wait = 0;
      if (mapped) begin
         if (s > TO) begin
            exp_wait = TO;
            exp_to   = 1'b1;
         end else begin
            exp_wait = s;
            if (rd && d > TO + 1) exp_to = 1'b1;
            else if (rd) exp_data = ref_fill(sd, be);
         end
      end
      waits = 0; valids = 0; pulses = 0; serr = 0;
      since = -1; stall_left = s; active = 1'b1;
      got = '0; to_a = '0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (since >= 0) since++;
         avalon_io_address    = a;
         avalon_io_byteenable = be;
         avalon_io_writedata  = wd;
         avalon_io_read  = active && rd;
         avalon_io_write = active && !rd;
         slv_waitrequest   = 4'($urandom);
         slv_readdatavalid = 4'($urandom);
         slv_readdata = {$urandom, $urandom,
                         $urandom, $urandom};
         slv_waitrequest[tgt] =
            mapped && active && stall_left > 0;
         slv_readdatavalid[tgt] = (since == d) ||
            (active && rd && mapped && stall_left == 0);
         if (since == d) slv_readdata[32*tgt +: 32] = sd;
         @(negedge clk);
         if (active) begin
            exp_w  = mapped && stall_left > 0 && waits < TO;
            exp_st = (mapped && !(stall_left > 0
                      && waits >= TO)) ? 4'(1 << tgt) : 4'b0;
            if (avalon_io_waitrequest !== exp_w) serr++;
            if (slv_read !== (rd ? exp_st : 4'b0)) serr++;
            if (slv_write !== (rd ? 4'b0 : exp_st)) serr++;
            if (avalon_io_waitrequest) waits++;
            else begin
               active = 1'b0;
               if (mapped && rd && stall_left == 0) since = 0;
            end
            if (stall_left > 0) stall_left--;
         end else if (slv_read !== 4'b0 || slv_write !== 4'b0) begin
            serr++;
         end
         if (io_timeout === 1'b1) begin
            pulses++;
            to_a = io_timeout_address;
         end
         if (avalon_io_readdatavalid === 1'b1) begin
            valids++;
            got = avalon_io_readdata;
         end
      end
      @(posedge clk); #1;
      idle_inputs();
      chk({tag, " waits"}, 32'(waits), 32'(exp_wait));
      chk({tag, " handshake"}, 32'(serr), 32'd0);
      chk({tag, " valids"}, 32'(valids), rd ? 32'd1 : 32'd0);
      if (rd) chk({tag, " rdata"}, got, exp_data);
      chk({tag, " pulses"}, 32'(pulses), 32'(exp_to));
      if (exp_to) chk({tag, " to_addr"}, 32'(to_a), 32'(a));
   endtask

   typedef struct {
      logic [15:0] addr;
      logic        rd;
      logic        wr;
      logic [3:0]  sw;
      logic [3:0]  e_rd;
      logic [3:0]  e_wr;
      logic        e_wait;
   } vec_t;

   vec_t vt[10];

   initial begin
      vt[0] = '{16'h0000, 1, 0, 4'b0000, 4'b0001, 4'b0000, 0};
      vt[1] = '{16'h001C, 0, 1, 4'b0001, 4'b0000, 4'b0001, 1};
      vt[2] = '{16'h0020, 1, 0, 4'b0001, 4'b0010, 4'b0000, 0};
      vt[3] = '{16'h003C, 0, 1, 4'b0010, 4'b0000, 4'b0010, 1};
      vt[4] = '{16'h0040, 1, 0, 4'b1011, 4'b0100, 4'b0000, 0};
      vt[5] = '{16'h007C, 0, 1, 4'b1000, 4'b0000, 4'b1000, 1};
      vt[6] = '{16'h0080, 1, 0, 4'b1111, 4'b0000, 4'b0000, 0};
      vt[7] = '{16'hFFFC, 0, 1, 4'b1111, 4'b0000, 4'b0000, 0};
      vt[8] = '{16'h0060, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0};
      vt[9] = '{16'h0100, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst rdv", 32'(avalon_io_readdatavalid), 32'd0);
      chk("rst rdata", avalon_io_readdata, 32'd0);
      chk("rst timeout", 32'(io_timeout), 32'd0);
      chk("rst to_addr", 32'(io_timeout_address), 32'd0);
      chk("rst wait", 32'(avalon_io_waitrequest), 32'd0);
      chk("rst strobes", {24'd0, slv_read, slv_write}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         avalon_io_address    = vt[i].addr;
         avalon_io_byteenable = 4'hF;
         avalon_io_read       = vt[i].rd;
         avalon_io_write      = vt[i].wr;
         slv_waitrequest      = vt[i].sw;
         #1;
         chk($sformatf("dec%0d rd", i),
             32'(slv_read), 32'(vt[i].e_rd));
         chk($sformatf("dec%0d wr", i),
             32'(slv_write), 32'(vt[i].e_wr));
         chk($sformatf("dec%0d wait", i),
             32'(avalon_io_waitrequest), 32'(vt[i].e_wait));
         #1;
         idle_inputs();
      end

      run_txn("wr24", 16'h0024, 4'b0011, 1'b0,
              32'h0000ABCD, 32'h0, 2, 1);
      run_txn("rd40", 16'h0040, 4'b0001, 1'b1,
              32'h0, 32'h12345678, 0, 3);
      run_txn("rd300", 16'h0300, 4'b1111, 1'b1,
              32'h0, 32'h0, 0, 1);
      run_txn("wr300", 16'h0300, 4'b1111, 1'b0,
              32'h55AA55AA, 32'h0, 0, 1);
      run_txn("to60", 16'h0060, 4'b1111, 1'b1,
              32'h0, 32'h0, 6, 1);
      run_txn("rwto", 16'h0000, 4'b1111, 1'b1,
              32'h0, 32'hDEADBEEF, 0, 7);

      // Reset while a read to slave 1 is pending.
      @(posedge clk); #1;
      avalon_io_address    = 16'h0020;
      avalon_io_byteenable = 4'hF;
      avalon_io_read       = 1'b1;
      @(negedge clk);
      chk("pend accept", 32'(avalon_io_waitrequest), 32'd0);
      @(posedge clk); #1;
      avalon_io_read    = 1'b0;
      avalon_io_write   = 1'b1;
      avalon_io_address = 16'h0024;
      @(negedge clk);
      chk("rw busy wait", 32'(avalon_io_waitrequest), 32'd1);
      chk("rw busy strobe", 32'(slv_write), 32'd0);
      avalon_io_write = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst rdata", avalon_io_readdata, 32'd0);
      chk("arst to_addr", 32'(io_timeout_address), 32'd0);
      chk("arst wait", 32'(avalon_io_waitrequest), 32'd0);
      chk("arst rdv", 32'(avalon_io_readdatavalid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      slv_readdatavalid = 4'b0010;
      slv_readdata[63:32] = 32'h11223344;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("arst late rdv", 32'(avalon_io_readdatavalid), 32'd0);
      run_txn("post_rst", 16'h0020, 4'b1111, 1'b1,
              32'h0, 32'hCAFEF00D, 0, 2);

      for (int n = 0; n < 40; n++) begin
         logic [15:0] ra;
         int rs;
         int rdl;
         if ($urandom_range(0, 3) != 0)
            ra = 16'($urandom_range(0, 31)) << 2;
         else
            ra = 16'($urandom_range(32, 16383)) << 2;
         rs = int'($urandom_range(0, 5));
         if (rs == 5) rs = 6;
         rdl = int'($urandom_range(1, 5));
         if (rdl == 5) rdl = 7;
         run_txn($sformatf("rnd%0d", n), ra, 4'($urandom),
                 1'($urandom), $urandom, $urandom, rs, rdl);
      end

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
